fetch_ctrl: RTL

Instruction-fetch sequencer for the MIPS32 core. Owns the program counter register, issues word fetches to instruction memory over a req/ack handshake, holds the fetched word until decode accepts it, and applies branch/jump redirects and exception vectoring. Sits between the instruction memory port and the decode stage and replaces the free-running PC register as the PC source.

---
 rtl/fetch_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// MIPS32 instruction-fetch sequencer: owns the PC, fetches over req/ack, and holds each word until decode takes it.
// One-cycle ack-to-valid and ready-to-req; stalls indefinitely on a missing ack or ready; redirects wait out a stale ack.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_exc,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, FLUSH} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr, instr_n;
  logic [31:0] pending, pending_n;
  logic        misaligned, misaligned_n;
  logic        evt;
  logic [31:0] target;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      instr      <= 32'h0;
      pending    <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      instr      <= instr_n;
      pending    <= pending_n;
      misaligned <= misaligned_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    instr_n      = instr;
    pending_n    = pending;
    misaligned_n = 1'b0;
    // Exception outranks a same-cycle branch; branch targets are forced word-aligned.
    evt    = (i_exc || i_redirect) && (state != IDLE);
    target = i_exc ? EXC_VECTOR : {i_redirect_pc[31:2], 2'b00};
    if (i_redirect && !i_exc && (state != IDLE) && (i_redirect_pc[1:0] != 2'b00))
      misaligned_n = 1'b1;

    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (evt) begin
          if (i_imem_ack) begin
            pc_n = target;
          end else begin
            pending_n = target;
            state_n   = FLUSH;
          end
        end else if (i_imem_ack) begin
          instr_n = i_imem_rdata;
          state_n = VALID;
        end
      end
      VALID: begin
        if (evt) begin
          pc_n    = target;
          state_n = FETCH;
        end else if (i_instr_ready) begin
          pc_n    = pc + 32'd4;
          state_n = FETCH;
        end
      end
      FLUSH: begin
        // The in-flight request must complete before the PC may move.
        if (evt) pending_n = target;
        if (i_imem_ack) begin
          pc_n    = evt ? target : pending;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_pc          = pc;
  assign o_imem_addr   = pc;
  assign o_imem_req    = (state == FETCH) || (state == FLUSH);
  assign o_instr       = instr;
  assign o_instr_valid = (state == VALID);
  assign o_misaligned  = misaligned;

endmodule
